// File: rtl/decode_stage_pipe_if.sv
// Decode-stage bus: fetch-side handshake, write-back port and the ID/EX outputs.
// The master drives fetch and write-back; the slave is the decode stage itself.
interface decode_stage_pipe_if #(
    parameter int DATA_W    = 24,
    parameter int REG_IDX_W = 4
);
    localparam int BUF_W = 15 + 3*REG_IDX_W + 4*DATA_W;

    logic                 en;
    logic                 in_valid;
    logic [31:0]          inst;
    logic                 flush;
    logic                 WE;
    logic [REG_IDX_W-1:0] Rd;
    logic [DATA_W-1:0]    WD;
    logic                 stall_out;
    logic                 out_valid;
    logic [BUF_W-1:0]     bufferOut;

    modport master (
        output en, in_valid, inst, flush, WE, Rd, WD,
        input  stall_out, out_valid, bufferOut
    );

    modport slave (
        input  en, in_valid, inst, flush, WE, Rd, WD,
        output stall_out, out_valid, bufferOut
    );
endinterface

// File: rtl/decode_stage_pipe.sv
// Decode stage: field split, control decode, bypassed register bank,
// load-use hazard detection and a flushable, valid-qualified ID/EX register.

// Control decode. Writes to R0 are discarded by dropping regWrite when Rc is zero.
module controlUnit #(
    parameter int REG_IDX_W = 4
) (
    input  logic [1:0]           opType,
    input  logic [3:0]           opCode,
    input  logic [REG_IDX_W-1:0] Rc,
    output logic                 immSrc,
    output logic                 branchFlag,
    output logic                 memWrite,
    output logic                 memToReg,
    output logic                 regWrite,
    output logic [3:0]           aluControl
);
    logic writesRc;

    always_comb begin
        immSrc     = 1'b0;
        branchFlag = 1'b0;
        memWrite   = 1'b0;
        memToReg   = 1'b0;
        writesRc   = 1'b0;
        aluControl = 4'd0;
        case (opType)
            2'b00: begin
                aluControl = opCode;
                writesRc   = 1'b1;
            end
            2'b01: begin
                aluControl = opCode;
                immSrc     = 1'b1;
                writesRc   = 1'b1;
            end
            2'b10: begin
                immSrc = 1'b1;
                if (opCode[0]) begin
                    memWrite = 1'b1;
                end else begin
                    memToReg = 1'b1;
                    writesRc = 1'b1;
                end
            end
            default: begin
                immSrc     = 1'b1;
                branchFlag = 1'b1;
                aluControl = 4'd1;
            end
        endcase
        regWrite = writesRc & (Rc != '0);
    end
endmodule

module decode_stage_pipe #(
    parameter int DATA_W    = 24,
    parameter int REG_IDX_W = 4,
    parameter int IMM_W     = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    decode_stage_pipe_if.slave   bus
);
    localparam int BUF_W     = 15 + 3*REG_IDX_W + 4*DATA_W;
    localparam int NUM_REGS  = 2**REG_IDX_W;
    localparam int RC_POS    = 2*DATA_W;
    localparam int CTRL_BASE = 4*DATA_W + 3*REG_IDX_W;

    logic [1:0]           opType;
    logic [3:0]           opCode;
    logic [REG_IDX_W-1:0] Rc;
    logic [REG_IDX_W-1:0] Ra;
    logic [REG_IDX_W-1:0] Rb;
    logic [IMM_W-1:0]     imm;
    logic [DATA_W-1:0]    extendImm;

    logic                 immSrc;
    logic                 branchFlag;
    logic                 memWrite;
    logic                 memToReg;
    logic                 regWrite;
    logic [3:0]           aluControl;

    logic [DATA_W-1:0]    regs [NUM_REGS];
    logic [DATA_W-1:0]    rd1;
    logic [DATA_W-1:0]    rd2;
    logic [DATA_W-1:0]    rd3;

    logic [BUF_W-1:0]     packedBus;
    logic [REG_IDX_W-1:0] exRc;
    logic                 exMemToReg;
    logic                 exRegWrite;
    logic                 loadUse;

    logic [BUF_W-1:0]     bufferReg;
    logic                 validReg;

    assign opType    = bus.inst[31:30];
    assign opCode    = bus.inst[29:26];
    assign Rc        = bus.inst[25 -: REG_IDX_W];
    assign Ra        = bus.inst[25-REG_IDX_W -: REG_IDX_W];
    assign Rb        = bus.inst[25-2*REG_IDX_W -: REG_IDX_W];
    assign imm       = bus.inst[IMM_W-1:0];
    assign extendImm = DATA_W'($signed(imm));

    controlUnit #(.REG_IDX_W(REG_IDX_W)) ctrl (
        .opType     (opType),
        .opCode     (opCode),
        .Rc         (Rc),
        .immSrc     (immSrc),
        .branchFlag (branchFlag),
        .memWrite   (memWrite),
        .memToReg   (memToReg),
        .regWrite   (regWrite),
        .aluControl (aluControl)
    );

    // Write-back is independent of the pipeline controls: it always lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.WE) begin
            regs[bus.Rd] <= bus.WD;
        end
    end

    // A same-cycle write-back is forwarded so decode never sees a stale value.
    always_comb begin
        rd1 = (bus.WE && (bus.Rd == Ra)) ? bus.WD : regs[Ra];
        rd2 = (bus.WE && (bus.Rd == Rb)) ? bus.WD : regs[Rb];
        rd3 = (bus.WE && (bus.Rd == Rc)) ? bus.WD : regs[Rc];
    end

    assign packedBus = {opType, opCode, immSrc, branchFlag, memWrite, memToReg,
                        regWrite, aluControl, Ra, rd1, Rb, rd2, Rc, rd3, extendImm};

    assign exRc       = bufferReg[RC_POS +: REG_IDX_W];
    assign exRegWrite = bufferReg[CTRL_BASE + 4];
    assign exMemToReg = bufferReg[CTRL_BASE + 5];

    // Stores read Rc as their data source, so only they compare against it.
    assign loadUse = validReg & exMemToReg & exRegWrite & bus.in_valid &
                     ((exRc == Ra) | (exRc == Rb) | (memWrite & (exRc == Rc)));

    assign bus.stall_out = loadUse & ~bus.flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bufferReg <= '0;
            validReg  <= 1'b0;
        end else if (bus.flush) begin
            bufferReg <= '0;
            validReg  <= 1'b0;
        end else if (bus.en) begin
            if (loadUse || !bus.in_valid) begin
                bufferReg <= '0;
                validReg  <= 1'b0;
            end else begin
                bufferReg <= packedBus;
                validReg  <= 1'b1;
            end
        end
    end

    assign bus.bufferOut = bufferReg;
    assign bus.out_valid = validReg;
endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
- Parametrised successor to the current decode stage.
- Splits the fetched instruction into fields, decodes the control flags through the existing controlUnit, and reads a parametrised register bank with write-to-read bypass.
- Detects load-use hazards against the instruction already in EX, stalls fetch and inserts a bubble.
- Registers everything into a valid-qualified ID/EX pipeline register that supports flush.

Parameters:
- DATA_W, 24, register and datapath width.
- REG_IDX_W, 4, register index width; the bank holds 2**REG_IDX_W registers.
- IMM_W, 18, immediate field width; must be <= DATA_W and <= 32-6-REG_IDX_W.
- BUF_W, 15+3*REG_IDX_W+4*DATA_W, ID/EX width; derived, must not be overridden (123 at defaults).

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  pipeline advance enable; 0 holds the ID/EX register.
- in_valid  in  1  inst carries a real instruction.
- inst  in  32  instruction word from IF/ID.
- flush  in  1  kill the instruction entering EX (branch taken).
- WE  in  1  write-back enable.
- Rd  in  REG_IDX_W  write-back destination index.
- WD  in  DATA_W  write-back data.
- stall_out  out  1  hold PC and IF/ID this cycle (combinational).
- out_valid  out  1  ID/EX entry is a real instruction.
- bufferOut  out  BUF_W  ID/EX register contents.

Behaviour:
- Field split:
  - opType = inst[31:30], opCode = inst[29:26].
  - Rc = inst[25:26-REG_IDX_W], Ra = next REG_IDX_W bits down, Rb = next REG_IDX_W bits down.
  - imm = inst[IMM_W-1:0]; extendImm = imm sign-extended to DATA_W.
- Control: controlUnit(opType, opCode, Rc) produces immSrc, branchFlag, memWrite, memToReg, regWrite and aluControl[3:0].
- Register bank:
  - Write at posedge clk when WE=1: regs[Rd] <= WD. Writes are independent of en, flush and stall.
  - Reads are combinational: RD1 = regs[Ra], RD2 = regs[Rb], RD3 = regs[Rc].
  - Bypass: if WE=1 and Rd equals a read index, that read returns WD in the same cycle.
- Bus packing, MSB to LSB: opType, opCode, immSrc, branchFlag, memWrite, memToReg, regWrite, aluControl, Ra, RD1, Rb, RD2, Rc, RD3, extendImm.
- EX-side fields (exRc, exMemToReg, exRegWrite) are taken from bufferOut.
- load_use = out_valid & exMemToReg & exRegWrite & in_valid & (exRc==Ra | exRc==Rb | (memWrite & exRc==Rc)).
- stall_out = load_use & ~flush.
- ID/EX update at posedge clk, highest priority first:
  1. flush=1: bufferOut <= 0, out_valid <= 0. Applies even when en=0.
  2. en=0: hold both.
  3. load_use=1: bubble, i.e. bufferOut <= 0, out_valid <= 0.
  4. in_valid=0: bubble.
  5. Otherwise: bufferOut <= packed bus, out_valid <= 1.
- Latency: one cycle from inst to bufferOut.
  - A stalled instruction stays on inst, because fetch holds it.
  - It is captured in the cycle after the bubble, since the EX entry is then a bubble and load_use drops.
- Reset (async, rst=1):
  - All registers, bufferOut and out_valid = 0.
  - stall_out = 0, because out_valid=0.
  - A reset mid-stall cancels the stall immediately.
- Simultaneous flush and load_use: the flush wins and stall_out=0.
- Simultaneous write-back and decode of the same register: the bypass supplies the new value, which is captured in ID/EX.

Test Plan:
1. Reset then read: pulse rst mid-cycle, then in_valid=1 with an instruction reading R3 -> RD1 field = 0, out_valid=1 one cycle later; bufferOut and out_valid=0 during rst with no clock edge required.
2. Bypass: WE=1, Rd=5, WD=0x00ABCD, same cycle as an instruction with Ra=5 -> captured RD1 = 0x00ABCD; the next read of R5 also returns 0x00ABCD.
3. Sign extend: imm=18'h20001 -> extendImm = 24'hFE0001; imm=18'h1FFFF -> 24'h01FFFF.
4. Load-use:
   - Cycle N: a load (memToReg=1, regWrite=1, Rc=7) is in ID/EX.
   - Next instruction has Rb=7 -> stall_out=1, next bufferOut=0 and out_valid=0.
   - The following cycle: stall_out=0 and the instruction is captured with out_valid=1.
   - Repeat with Rb=8 -> no stall.
5. Flush priority: load_use condition, flush=1 and en=0 all together -> stall_out=0, bufferOut=0 and out_valid=0 after the edge.
6. Hold: en=0, flush=0 for 3 cycles while inst changes -> bufferOut and out_valid unchanged. A write-back WE=1, Rd=2, WD=0x000011 during the hold still updates R2, verified by a later read.
